// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// - state_e : FSM states (idle, access in flight, completion pulse)
// - PrioData / PrioRr : arbitration mode selectors for PRIO_MODE
// - ChI / ChD : channel identifiers (instruction fetch, load/store)
// - arb_winner : picks the winner when both channels request at once
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned PrioData = 0;
  localparam int unsigned PrioRr   = 1;

  localparam logic ChI = 1'b0;
  localparam logic ChD = 1'b1;

  // Contention winner; round-robin hands the grant to the channel not served last.
  function automatic logic arb_winner(input int unsigned mode, input logic last_grant);
    case (mode)
      PrioData: return ChD;
      PrioRr:   return (last_grant == ChI) ? ChD : ChI;
      default:  return ChD;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Ports:
//   clk - clock
//   clr - synchronous clear (wins over inc)
//   inc - count enable; ignored once the counter reaches all-ones
//   cnt - current count
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle single-ported memory between the instruction-fetch channel (1)
// and the load/store channel (2). One access is in flight at a time; the served channel
// sees a one-cycle ready pulse with its data. Per-channel stall cycles are counted.
// Ports:
//   Clk, Reset_N                  - clock; synchronous active-high reset
//   readM1, address1, data1, ready1 - fetch channel request / completion
//   readM2, writeM2, address2, wdata2, rdata2, ready2 - load/store channel
//   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, mem_ack - memory side
//   num_stall1, num_stall2        - saturating stall-cycle counters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  readM1,
  input  logic [ADDR_WIDTH-1:0] address1,
  output logic [WORD_SIZE-1:0]  data1,
  output logic                  ready1,
  input  logic                  readM2,
  input  logic                  writeM2,
  input  logic [ADDR_WIDTH-1:0] address2,
  input  logic [WORD_SIZE-1:0]  wdata2,
  output logic [WORD_SIZE-1:0]  rdata2,
  output logic                  ready2,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  num_stall1,
  output logic [CNT_WIDTH-1:0]  num_stall2
);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  ready1_q, ready1_d;
  logic                  ready2_q, ready2_d;
  logic [WORD_SIZE-1:0]  data1_q, data1_d;
  logic [WORD_SIZE-1:0]  rdata2_q, rdata2_d;

  logic req1, req2, winner;

  assign req1 = readM1;
  assign req2 = readM2 | writeM2;

  always_comb begin
    if (req1 && req2) begin
      winner = arb_winner(PRIO_MODE, last_grant_q);
    end else if (req2) begin
      winner = ChD;
    end else begin
      winner = ChI;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ready1_d     = 1'b0;
    ready2_d     = 1'b0;
    data1_d      = data1_q;
    rdata2_d     = rdata2_q;

    case (state_q)
      StIdle: begin
        if (req1 || req2) begin
          state_d      = StBusy;
          grant_d      = winner;
          last_grant_d = winner;
          if (winner == ChD) begin
            // A write wins over a simultaneous read request.
            mem_write_d = writeM2;
            mem_read_d  = ~writeM2;
            mem_addr_d  = address2;
            mem_wdata_d = wdata2;
          end else begin
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
            mem_addr_d  = address1;
            mem_wdata_d = '0;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d     = StDone;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (grant_q == ChI) begin
            ready1_d = 1'b1;
            data1_d  = mem_rdata;
          end else begin
            ready2_d = 1'b1;
            if (mem_read_q) begin
              rdata2_d = mem_rdata;
            end
          end
        end
      end
      StDone: begin
        // Requests are ignored here so a held request starts a fresh access from idle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_N) begin
      state_q      <= StIdle;
      grant_q      <= ChI;
      last_grant_q <= ChI;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ready1_q     <= 1'b0;
      ready2_q     <= 1'b0;
      data1_q      <= '0;
      rdata2_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ready1_q     <= ready1_d;
      ready2_q     <= ready2_d;
      data1_q      <= data1_d;
      rdata2_q     <= rdata2_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ready1    = ready1_q;
  assign ready2    = ready2_q;
  assign data1     = data1_q;
  assign rdata2    = rdata2_q;

  // A cycle counts as stalled while the request is up and its ready has not arrived.
  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall1 (
    .clk(Clk),
    .clr(Reset_N),
    .inc(req1 & ~ready1_q),
    .cnt(num_stall1)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall2 (
    .clk(Clk),
    .clr(Reset_N),
    .inc(req2 & ~ready2_q),
    .cnt(num_stall2)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        readM1, readM2, writeM2, mem_ack;
  logic [15:0] address1, address2, wdata2, mem_rdata;

  // dut0: data-first priority, dut1: round-robin, dut2: 4-bit counters
  logic [15:0] d0_data1, d0_rdata2, d0_mem_addr, d0_mem_wdata, d0_st1, d0_st2;
  logic        d0_ready1, d0_ready2, d0_mem_read, d0_mem_write;
  logic [15:0] d1_data1, d1_rdata2, d1_mem_addr, d1_mem_wdata, d1_st1, d1_st2;
  logic        d1_ready1, d1_ready2, d1_mem_read, d1_mem_write;
  logic [15:0] d2_data1, d2_rdata2, d2_mem_addr, d2_mem_wdata;
  logic [3:0]  d2_st1, d2_st2;
  logic        d2_ready1, d2_ready2, d2_mem_read, d2_mem_write;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(16), .PRIO_MODE(0), .CNT_WIDTH(16)) dut0 (
    .Clk(clk), .Reset_N(rst), .readM1(readM1), .address1(address1), .data1(d0_data1),
    .ready1(d0_ready1), .readM2(readM2), .writeM2(writeM2), .address2(address2),
    .wdata2(wdata2), .rdata2(d0_rdata2), .ready2(d0_ready2), .mem_read(d0_mem_read),
    .mem_write(d0_mem_write), .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .num_stall1(d0_st1), .num_stall2(d0_st2)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(16), .PRIO_MODE(1), .CNT_WIDTH(16)) dut1 (
    .Clk(clk), .Reset_N(rst), .readM1(readM1), .address1(address1), .data1(d1_data1),
    .ready1(d1_ready1), .readM2(readM2), .writeM2(writeM2), .address2(address2),
    .wdata2(wdata2), .rdata2(d1_rdata2), .ready2(d1_ready2), .mem_read(d1_mem_read),
    .mem_write(d1_mem_write), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .num_stall1(d1_st1), .num_stall2(d1_st2)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(16), .PRIO_MODE(0), .CNT_WIDTH(4)) dut2 (
    .Clk(clk), .Reset_N(rst), .readM1(readM1), .address1(address1), .data1(d2_data1),
    .ready1(d2_ready1), .readM2(readM2), .writeM2(writeM2), .address2(address2),
    .wdata2(wdata2), .rdata2(d2_rdata2), .ready2(d2_ready2), .mem_read(d2_mem_read),
    .mem_write(d2_mem_write), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .num_stall1(d2_st1), .num_stall2(d2_st2)
  );

  typedef struct {
    logic rd1; logic [15:0] a1; logic rd2; logic wr2; logic [15:0] a2; logic [15:0] wd2;
    logic [15:0] mrd; logic ack;
    logic e_rdy1; logic [15:0] e_d1; logic e_rdy2; logic [15:0] e_rd2;
    logic e_mr; logic e_mw; logic [15:0] e_ma; logic [15:0] e_mwd;
    logic [15:0] e_st1; logic [15:0] e_st2;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; readM1 = 1'b0; readM2 = 1'b0; writeM2 = 1'b0; mem_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " data1"}, {16'h0, d0_data1}, 32'h0);
    chk({tag, " ready1"}, {31'h0, d0_ready1}, 32'h0);
    chk({tag, " rdata2"}, {16'h0, d0_rdata2}, 32'h0);
    chk({tag, " ready2"}, {31'h0, d0_ready2}, 32'h0);
    chk({tag, " mem_read"}, {31'h0, d0_mem_read}, 32'h0);
    chk({tag, " mem_write"}, {31'h0, d0_mem_write}, 32'h0);
    chk({tag, " mem_addr"}, {16'h0, d0_mem_addr}, 32'h0);
    chk({tag, " mem_wdata"}, {16'h0, d0_mem_wdata}, 32'h0);
    chk({tag, " num_stall1"}, {16'h0, d0_st1}, 32'h0);
    chk({tag, " num_stall2"}, {16'h0, d0_st2}, 32'h0);
    chk({tag, " d2 num_stall1"}, {28'h0, d2_st1}, 32'h0);
  endtask

  // Memory responder: ack in the first busy cycle of the chosen DUT, data keyed by address.
  task automatic respond(input bit use_rr);
    if (use_rr) begin
      mem_ack   = d1_mem_read | d1_mem_write;
      mem_rdata = (d1_mem_addr == 16'h0020) ? 16'h1234 : 16'h6A01;
    end else begin
      mem_ack   = d0_mem_read | d0_mem_write;
      mem_rdata = (d0_mem_addr == 16'h0020) ? 16'h1234 : 16'h6A01;
    end
  endtask

  initial begin
    int t, t1, t2, n;
    int order[4];
    int exp_order[4];
    logic [3:0] sat;
    exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 1;

    // rd1 a1 rd2 wr2 a2 wd2 mrd ack | rdy1 d1 rdy2 rd2 mr mw ma mwd st1 st2
    vecs[0]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'd1, 16'd0};
    vecs[1]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h6A01, 1'b1,
                 1'b1, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'd2, 16'd0};
    vecs[2]  = '{1'b0, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'd2, 16'd0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 16'hBEEF, 16'd2, 16'd1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 16'hBEEF, 16'd2, 16'd2};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 16'hBEEF, 16'd2, 16'd3};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 16'hBEEF, 16'd2, 16'd4};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h5555, 1'b1,
                 1'b0, 16'h6A01, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0030, 16'hBEEF, 16'd2, 16'd5};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0030, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0030, 16'hBEEF, 16'd2, 16'd5};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'd2, 16'd6};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h1234, 1'b1,
                 1'b0, 16'h6A01, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 16'd2, 16'd7};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 16'd2, 16'd7};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h7777, 1'b1,
                 1'b0, 16'h6A01, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'd2, 16'd8};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0A0A, 1'b1,
                 1'b0, 16'h6A01, 1'b1, 16'h0A0A, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 16'd2, 16'd9};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0,
                 1'b0, 16'h6A01, 1'b0, 16'h0A0A, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 16'd2, 16'd9};

    rst = 1'b1; readM1 = 1'b0; readM2 = 1'b0; writeM2 = 1'b0; mem_ack = 1'b0;
    address1 = '0; address2 = '0; wdata2 = '0; mem_rdata = '0;
    do_reset();
    chk_zero("reset");

    // Fetch, delayed store, load, held request and stray ack, cycle by cycle on dut0.
    for (int i = 0; i < 15; i++) begin
      readM1 = vecs[i].rd1; address1 = vecs[i].a1; readM2 = vecs[i].rd2;
      writeM2 = vecs[i].wr2; address2 = vecs[i].a2; wdata2 = vecs[i].wd2;
      mem_rdata = vecs[i].mrd; mem_ack = vecs[i].ack;
      tick();
      chk($sformatf("v%0d ready1", i), {31'h0, d0_ready1}, {31'h0, vecs[i].e_rdy1});
      chk($sformatf("v%0d data1", i), {16'h0, d0_data1}, {16'h0, vecs[i].e_d1});
      chk($sformatf("v%0d ready2", i), {31'h0, d0_ready2}, {31'h0, vecs[i].e_rdy2});
      chk($sformatf("v%0d rdata2", i), {16'h0, d0_rdata2}, {16'h0, vecs[i].e_rd2});
      chk($sformatf("v%0d mem_read", i), {31'h0, d0_mem_read}, {31'h0, vecs[i].e_mr});
      chk($sformatf("v%0d mem_write", i), {31'h0, d0_mem_write}, {31'h0, vecs[i].e_mw});
      chk($sformatf("v%0d mem_addr", i), {16'h0, d0_mem_addr}, {16'h0, vecs[i].e_ma});
      chk($sformatf("v%0d mem_wdata", i), {16'h0, d0_mem_wdata}, {16'h0, vecs[i].e_mwd});
      chk($sformatf("v%0d num_stall1", i), {16'h0, d0_st1}, {16'h0, vecs[i].e_st1});
      chk($sformatf("v%0d num_stall2", i), {16'h0, d0_st2}, {16'h0, vecs[i].e_st2});
    end

    // Data-first contention: channel 2 served first, channel 1 three cycles later.
    do_reset();
    readM1 = 1'b1; address1 = 16'h0004; readM2 = 1'b1; writeM2 = 1'b0; address2 = 16'h0020;
    t = 0; t1 = -1; t2 = -1;
    for (int c = 0; c < 30 && t1 < 0; c++) begin
      tick();
      t++;
      if (d0_ready2) begin
        t2 = t;
        chk("prio0 rdata2", {16'h0, d0_rdata2}, 32'h1234);
        readM2 = 1'b0;
      end
      if (d0_ready1) begin
        t1 = t;
        chk("prio0 data1", {16'h0, d0_data1}, 32'h6A01);
        readM1 = 1'b0;
      end
      respond(1'b0);
    end
    chk("prio0 ready2 cycle", t2, 2);
    chk("prio0 ready1 cycle", t1, 5);
    chk("prio0 spacing", t1 - t2, 3);

    // Round-robin with both requests held: grants alternate starting with channel 2.
    do_reset();
    readM1 = 1'b1; address1 = 16'h0004; readM2 = 1'b1; writeM2 = 1'b0; address2 = 16'h0020;
    n = 0;
    for (int k = 0; k < 4; k++) order[k] = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (d1_ready1 && n < 4) begin order[n] = 1; n++; end
      if (d1_ready2 && n < 4) begin order[n] = 2; n++; end
      respond(1'b1);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr grant %0d", k), order[k], exp_order[k]);
    chk("rr rdata2", {16'h0, d1_rdata2}, 32'h1234);
    chk("rr data1", {16'h0, d1_data1}, 32'h6A01);

    // Saturation on the 4-bit counter, with the fetch stuck waiting for an ack.
    do_reset();
    readM1 = 1'b1; address1 = 16'h0010; readM2 = 1'b0; writeM2 = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sat = (i + 1 > 15) ? 4'hF : 4'(i + 1);
      chk($sformatf("sat cycle %0d", i), {28'h0, d2_st1}, {28'h0, sat});
    end
    chk("midbusy mem_read", {31'h0, d0_mem_read}, 32'h1);
    chk("midbusy mem_addr", {16'h0, d0_mem_addr}, 32'h0010);

    // Reset in the middle of the access abandons it.
    rst = 1'b1;
    tick();
    rst = 1'b0; readM1 = 1'b0;
    chk_zero("midbusy reset");
    mem_ack = 1'b1;
    tick();
    chk("post-reset stray ack ready1", {31'h0, d0_ready1}, 32'h0);
    chk("post-reset stray ack mem_read", {31'h0, d0_mem_read}, 32'h0);
    mem_ack = 1'b0; readM1 = 1'b1; address1 = 16'h0044;
    tick();
    chk("post-reset idle grant mem_read", {31'h0, d0_mem_read}, 32'h1);
    chk("post-reset idle grant mem_addr", {16'h0, d0_mem_addr}, 32'h0044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle, single-ported unified memory between the CPU's two memory channels.
  - Channel 1: instruction fetch (readM1 / address1 / data1).
  - Channel 2: load/store (readM2 / writeM2 / address2 / data).
- Stalls each channel with a per-channel ready until its access completes.
- Arbitrates simultaneous requests under a compile-time priority mode.
- Counts per-channel stall cycles for performance reporting alongside num_inst.

Parameters:
- WORD_SIZE, 16, data word width.
- ADDR_WIDTH, 16, address width.
- PRIO_MODE, 0, arbitration mode: 0 = data channel always first, 1 = round-robin.
- CNT_WIDTH, 16, width of the stall counters.

Ports:
- Clk  input  1  clock, all state on rising edge.
- Reset_N  input  1  reset, synchronous, active-high.
- readM1  input  1  channel-1 read request, held until ready1.
- address1  input  ADDR_WIDTH  channel-1 address.
- data1  output  WORD_SIZE  channel-1 read data, valid when ready1=1.
- ready1  output  1  channel-1 completion pulse.
- readM2  input  1  channel-2 read request, held until ready2.
- writeM2  input  1  channel-2 write request, held until ready2.
- address2  input  ADDR_WIDTH  channel-2 address.
- wdata2  input  WORD_SIZE  channel-2 store data.
- rdata2  output  WORD_SIZE  channel-2 load data, valid when ready2=1.
- ready2  output  1  channel-2 completion pulse.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data, valid when mem_ack=1.
- mem_ack  input  1  memory completion, one cycle.
- num_stall1  output  CNT_WIDTH  channel-1 stall cycle count.
- num_stall2  output  CNT_WIDTH  channel-2 stall cycle count.

Behaviour:
- Reset:
  - Every output is 0.
  - FSM goes to IDLE and last_grant is set to channel 1.
  - Reset has priority over all events, including mid-BUSY. Any in-flight access is abandoned and no ready is issued for it.
- FSM has three states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - If any request is present at an edge, latch the granted channel's op, address and wdata, then go to BUSY.
  - Otherwise stay in IDLE.
- Channel 2 op decode: writeM2=1 means write (writeM2 wins if both readM2 and writeM2 are high). Otherwise readM2=1 means read.
- Grant rules:
  - Only one request present: that channel wins.
  - Both present, PRIO_MODE=0: channel 2 wins.
  - Both present, PRIO_MODE=1: the channel not equal to last_grant wins. last_grant updates on every grant.
- BUSY:
  - mem_read or mem_write, mem_addr and mem_wdata are held constant from the latched values.
  - On a cycle with mem_ack=1, capture mem_rdata (reads only) and go to DONE.
  - The memory strobe drops at the edge leaving BUSY.
  - There is no timeout: the block waits indefinitely for mem_ack.
- DONE:
  - The granted channel's ready is 1 for exactly one cycle.
  - Its data output carries the captured word; data1/rdata2 hold that value until the next completion on the same channel.
  - Requests are ignored in DONE; the next edge returns to IDLE.
  - A requester that keeps its request asserted after its ready is treated as a new access in IDLE.
- Writes: ready2 pulses in DONE; rdata2 is unchanged.
- Latency: a request first seen at edge T with mem_ack in the first BUSY cycle gives ready at cycle T+2. Each additional memory wait cycle adds 1.
- Losing channel: stays pending and is granted in the IDLE immediately after DONE (minimum 3-cycle spacing between accesses).
- Stall counters:
  - num_stallX increments on each edge where the channel's request is high and readyX=0.
  - The counters saturate at all-ones and never wrap.
  - Only reset clears them.
- Changing address or op while a request is pending is a protocol violation. The latched values are used.
- mem_ack outside BUSY is ignored.

Decomposition:
- Shared include (mem_arb_defs.v, same style as the opcode header):
  - FSM state encodings IDLE/BUSY/DONE.
  - PRIO_MODE constants PRIO_DATA=0 and PRIO_RR=1.
  - Channel IDs CH_I=0 and CH_D=1.
- One sub-module: sat_counter (CNT_WIDTH-parameterised saturating counter with synchronous active-high clear), instantiated twice for num_stall1 and num_stall2.

Test Plan:
- Reset mid-BUSY (readM1=1, address1=16'h0010, no ack, Reset_N pulsed high): next cycle all outputs are 0, no ready1 pulse, FSM is IDLE.
- Single fetch (readM1=1, address1=16'h0004, mem_rdata=16'h6A01, mem_ack on the first BUSY cycle): ready1=1 at T+2 with data1=16'h6A01; num_stall1=2.
- PRIO_MODE=0 contention (readM1 and readM2 high together, address2=16'h0020, mem_rdata=16'h1234):
  - channel 2 is served first, rdata2=16'h1234;
  - channel 1 is granted in the IDLE after DONE;
  - ready1 pulses exactly 3 cycles after ready2.
- PRIO_MODE=1 contention (both channels request continuously for 4 accesses): grant order is 2,1,2,1 (last_grant is 1 after reset).
- Store (writeM2=1 and readM2=1, address2=16'h0030, wdata2=16'hBEEF, mem_ack delayed 3 cycles):
  - mem_write=1 and mem_read=0 throughout BUSY, with mem_wdata=16'hBEEF;
  - ready2 at T+5; rdata2 unchanged.
- Saturation (CNT_WIDTH=4, readM1 held with no mem_ack for 20 cycles): num_stall1 stops at 4'hF and does not wrap.
